// File: rtl/modport_alu.sv
// Registered RV32I execute-stage ALU: combinational datapath into one output register.
// Define ALU_MUL_EN to decode alu_cntr 1011 as a signed 32x32 MUL (low word result).
module modport_alu (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  alu_cntr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_result,
    output logic        o_flag,
    output logic        z_flag
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1010;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

    logic [4:0]  shamt;
    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;
    logic [31:0] res_d;
    logic        ovf_d;
    logic        zero_d;
    logic [31:0] res_q;
    logic        ovf_q;
    logic        zero_q;

    assign shamt = b[4:0];
    assign sum   = a + b;
    assign diff  = a - b;

    // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips.
    assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

`ifdef ALU_MUL_EN
    logic signed [63:0] prod;
    logic               mul_ovf;

    assign prod    = $signed(a) * $signed(b);
    assign mul_ovf = (prod[63:32] != {32{prod[31]}});
`endif

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        unique case (alu_cntr)
            OP_ADD: begin
                res_d = sum;
                ovf_d = add_ovf;
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = sub_ovf;
            end
            OP_SLL:  res_d = a << shamt;
            OP_SLT:  res_d = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: res_d = {31'b0, a < b};
            OP_XOR:  res_d = a ^ b;
            OP_SRL:  res_d = a >> shamt;
            OP_SRA:  res_d = $unsigned($signed(a) >>> shamt);
            OP_OR:   res_d = a | b;
            OP_AND:  res_d = a & b;
            OP_PASS: res_d = b;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res_d = prod[31:0];
                ovf_d = mul_ovf;
            end
`endif
            default: begin
                res_d = '0;
                ovf_d = 1'b0;
            end
        endcase
    end

    assign zero_d = (res_d == 32'd0);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            res_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign alu_result = res_q;
    assign o_flag     = ovf_q;
    assign z_flag     = zero_q;

endmodule

// File: tb/tb_modport_alu.sv
// Self-checking bench for modport_alu: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_modport_alu;

    logic        clk;
    logic        rstn;
    logic [3:0]  alu_cntr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_result;
    logic        o_flag;
    logic        z_flag;

    int n_checks = 0;
    int n_fails  = 0;

    modport_alu dut (
        .clk        (clk),
        .rstn       (rstn),
        .alu_cntr   (alu_cntr),
        .a          (a),
        .b          (b),
        .alu_result (alu_result),
        .o_flag     (o_flag),
        .z_flag     (z_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: evaluates each operation with 64-bit integer arithmetic.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x,
                                    input logic [31:0] y, output logic [31:0] r,
                                    output logic o);
        longint sx;
        longint sy;
        longint wide;
        int     amt;
        sx   = $signed(x);
        sy   = $signed(y);
        amt  = int'(y % 32);
        r    = 32'd0;
        o    = 1'b0;
        wide = 0;
        case (op)
            4'd0: begin
                wide = sx + sy;
                r    = wide[31:0];
                o    = (wide != {{32{wide[31]}}, wide[31:0]});
            end
            4'd1: begin
                wide = sx - sy;
                r    = wide[31:0];
                o    = (wide != {{32{wide[31]}}, wide[31:0]});
            end
            4'd2: begin
                wide = longint'(x) * (longint'(1) << amt);
                r    = wide[31:0];
            end
            4'd3: r = (sx < sy) ? 32'd1 : 32'd0;
            4'd4: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
            4'd5: r = x ^ y;
            4'd6: begin
                wide = longint'(x) / (longint'(1) << amt);
                r    = wide[31:0];
            end
            4'd7: begin
                wide = sx >>> amt;
                r    = wide[31:0];
            end
            4'd8:  r = x | y;
            4'd9:  r = x & y;
            4'd10: r = y;
`ifdef ALU_MUL_EN
            4'd11: begin
                wide = sx * sy;
                r    = wide[31:0];
                o    = (wide != {{32{wide[31]}}, wide[31:0]});
            end
`endif
            default: begin
                r = 32'd0;
                o = 1'b0;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        corners[5] = 32'h0001_0000;
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_reset();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_cntr = 4'($urandom);
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            n_checks++;
            if (alu_result !== 32'd0) begin
                n_fails++;
                $display("FAIL reset_result: got %h want 00000000", alu_result);
            end
            n_checks++;
            if (o_flag !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_oflag: got %b want 0", o_flag);
            end
            n_checks++;
            if (z_flag !== 1'b1) begin
                n_fails++;
                $display("FAIL reset_zflag: got %b want 1", z_flag);
            end
        end
        rstn = 1'b0;
        alu_cntr = 4'b0000;
        a = 32'd5;
        b = 32'd7;
        #2;
        n_checks++;
        if (alu_result !== 32'd0 || z_flag !== 1'b1) begin
            n_fails++;
            $display("FAIL release_no_capture: got %h z=%b want 00000000 z=1",
                     alu_result, z_flag);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (alu_result !== 32'd12) begin
            n_fails++;
            $display("FAIL first_add: got %h want 0000000c", alu_result);
        end
        n_checks++;
        if (z_flag !== 1'b0 || o_flag !== 1'b0) begin
            n_fails++;
            $display("FAIL first_add_flags: got o=%b z=%b want o=0 z=0",
                     o_flag, z_flag);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [10];
        logic [31:0] xa  [10];
        logic [31:0] xb  [10];
        logic [31:0] er  [10];
        logic        eo  [10];
        logic        ez  [10];
        ops[0] = 4'd0;  xa[0] = 32'h7FFF_FFFF; xb[0] = 32'd1;
        er[0] = 32'h8000_0000; eo[0] = 1; ez[0] = 0;
        ops[1] = 4'd1;  xa[1] = 32'h8000_0000; xb[1] = 32'd1;
        er[1] = 32'h7FFF_FFFF; eo[1] = 1; ez[1] = 0;
        ops[2] = 4'd0;  xa[2] = 32'hFFFF_FFFF; xb[2] = 32'd1;
        er[2] = 32'h0; eo[2] = 0; ez[2] = 1;
        ops[3] = 4'd7;  xa[3] = 32'h8000_0000; xb[3] = 32'h24;
        er[3] = 32'hF800_0000; eo[3] = 0; ez[3] = 0;
        ops[4] = 4'd6;  xa[4] = 32'h8000_0000; xb[4] = 32'h24;
        er[4] = 32'h0800_0000; eo[4] = 0; ez[4] = 0;
        ops[5] = 4'd2;  xa[5] = 32'd1; xb[5] = 32'd31;
        er[5] = 32'h8000_0000; eo[5] = 0; ez[5] = 0;
        ops[6] = 4'd3;  xa[6] = 32'hFFFF_FFFF; xb[6] = 32'd1;
        er[6] = 32'd1; eo[6] = 0; ez[6] = 0;
        ops[7] = 4'd4;  xa[7] = 32'hFFFF_FFFF; xb[7] = 32'd1;
        er[7] = 32'd0; eo[7] = 0; ez[7] = 1;
        ops[8] = 4'd15; xa[8] = 32'h1234_5678; xb[8] = 32'h9ABC_DEF0;
        er[8] = 32'd0; eo[8] = 0; ez[8] = 1;
`ifdef ALU_MUL_EN
        ops[9] = 4'd11; xa[9] = 32'h0001_0000; xb[9] = 32'h0001_0000;
        er[9] = 32'd0; eo[9] = 1; ez[9] = 1;
`else
        ops[9] = 4'd11; xa[9] = 32'h0000_0003; xb[9] = 32'h0000_0005;
        er[9] = 32'd0; eo[9] = 0; ez[9] = 1;
`endif
        for (int i = 0; i < 10; i++) begin
            alu_cntr = ops[i];
            a = xa[i];
            b = xb[i];
            @(posedge clk);
            #1;
            n_checks++;
            if (alu_result !== er[i]) begin
                n_fails++;
                $display("FAIL directed%0d_result op=%h: got %h want %h",
                         i, ops[i], alu_result, er[i]);
            end
            n_checks++;
            if (o_flag !== eo[i]) begin
                n_fails++;
                $display("FAIL directed%0d_oflag op=%h: got %b want %b",
                         i, ops[i], o_flag, eo[i]);
            end
            n_checks++;
            if (z_flag !== ez[i]) begin
                n_fails++;
                $display("FAIL directed%0d_zflag op=%h: got %b want %b",
                         i, ops[i], z_flag, ez[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4];
        logic [31:0] er  [4];
        ops[0] = 4'd9;  er[0] = 32'h00F0_00F0;
        ops[1] = 4'd8;  er[1] = 32'hFFF0_FFF0;
        ops[2] = 4'd5;  er[2] = 32'hFF00_FF00;
        ops[3] = 4'd10; er[3] = 32'h0FF0_0FF0;
        a = 32'hF0F0_F0F0;
        b = 32'h0FF0_0FF0;
        for (int i = 0; i < 4; i++) begin
            alu_cntr = ops[i];
            @(posedge clk);
            #1;
            n_checks++;
            if (alu_result !== er[i] || z_flag !== 1'b0 || o_flag !== 1'b0) begin
                n_fails++;
                $display("FAIL b2b%0d: got %h o=%b z=%b want %h o=0 z=0",
                         i, alu_result, o_flag, z_flag, er[i]);
            end
        end
        alu_cntr = ops[0];
        @(posedge clk);
        #1;
        alu_cntr = ops[2];
        #2;
        rstn = 1'b1;
        #1;
        n_checks++;
        if (alu_result !== 32'd0 || o_flag !== 1'b0 || z_flag !== 1'b1) begin
            n_fails++;
            $display("FAIL midstream_reset: got %h o=%b z=%b want 0 o=0 z=1",
                     alu_result, o_flag, z_flag);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (alu_result !== 32'd0 || z_flag !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_hold: got %h z=%b want 0 z=1", alu_result, z_flag);
        end
        rstn = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (alu_result !== er[2] || z_flag !== 1'b0) begin
            n_fails++;
            $display("FAIL post_reset_op: got %h z=%b want %h z=0",
                     alu_result, z_flag, er[2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] er;
        logic        eo;
        for (int i = 0; i < 400; i++) begin
            alu_cntr = 4'($urandom_range(0, 15));
            a = pick_operand();
            b = pick_operand();
            ref_alu(alu_cntr, a, b, er, eo);
            @(posedge clk);
            #1;
            n_checks++;
            if (alu_result !== er || o_flag !== eo || z_flag !== (er == 32'd0)) begin
                n_fails++;
                $display("FAIL random%0d op=%h a=%h b=%h: got %h o=%b z=%b want %h o=%b z=%b",
                         i, alu_cntr, a, b, alu_result, o_flag, z_flag,
                         er, eo, (er == 32'd0));
            end
            #2;
            alu_cntr = 4'($urandom);
            a = $urandom;
            b = $urandom;
            #1;
            n_checks++;
            if (alu_result !== er || o_flag !== eo) begin
                n_fails++;
                $display("FAIL hold%0d: got %h o=%b want %h o=%b",
                         i, alu_result, o_flag, er, eo);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        alu_cntr = 4'd0;
        a = 32'd0;
        b = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
